// File: rtl/fixed_point_pkg.sv
// Shared fixed-point definitions for the MLP datapath (divider and multiplier).
// Word format is Q(BITS-FRAC_BITS).FRAC_BITS, two's complement.
package fixed_point_pkg;

  localparam int unsigned BITS      = 16;
  localparam int unsigned FRAC_BITS = 11;

  typedef logic signed [BITS-1:0] fixed_t;

  localparam fixed_t QMAX = {1'b0, {(BITS-1){1'b1}}};
  localparam fixed_t QMIN = {1'b1, {(BITS-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fixed_point_divider_if.sv
// Operand/result handshake bundle of the fixed-point divider.
// master drives operands and out_ready; slave is the divider.
interface fixed_point_divider_if;
  import fixed_point_pkg::*;

  logic   in_valid;
  logic   in_ready;
  fixed_t Dividend;
  fixed_t Divisor;
  logic   out_valid;
  logic   out_ready;
  fixed_t Quotient;
  logic   div_by_zero;
  logic   overflow;

  modport master (
    output in_valid, Dividend, Divisor, out_ready,
    input  in_ready, out_valid, Quotient, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, Dividend, Divisor, out_ready,
    output in_ready, out_valid, Quotient, div_by_zero, overflow
  );

endinterface

// File: rtl/fixed_point_saturate.sv
// Applies a sign to an unsigned magnitude and clamps it into fixed_t range.
// Negative results may reach 2^(BITS-1) in magnitude; positive ones only QMAX.
module fixed_point_saturate
  import fixed_point_pkg::*;
#(
  parameter int unsigned MagW = BITS + FRAC_BITS
) (
  input  logic [MagW-1:0] mag,
  input  logic            neg,
  output fixed_t          value,
  output logic            overflow
);

  localparam logic [MagW-1:0] PosLim = {{(MagW-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
  localparam logic [MagW-1:0] NegLim = {{(MagW-BITS){1'b0}}, 1'b1, {(BITS-1){1'b0}}};

  logic [BITS-1:0] low;

  always_comb begin
    low      = mag[BITS-1:0];
    overflow = 1'b0;
    value    = neg ? fixed_t'(~low + 1'b1) : fixed_t'(low);
    if (neg && (mag > NegLim)) begin
      value    = QMIN;
      overflow = 1'b1;
    end else if (!neg && (mag > PosLim)) begin
      value    = QMAX;
      overflow = 1'b1;
    end
  end

endmodule

// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider: Quotient = (Dividend <<< FRAC_BITS) / Divisor,
// restoring shift-subtract on magnitudes, one quotient bit per cycle, MSB first.
module fixed_point_divider
  import fixed_point_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  fixed_point_divider_if.slave bus
);

  localparam int unsigned MagW = BITS + 1;
  localparam int unsigned NumW = BITS + FRAC_BITS;
  localparam int unsigned CntW = $clog2(NumW + 1);

  state_e          state_q, state_d;
  logic [MagW-1:0] dvs_q, rem_q;
  logic [NumW-1:0] num_q, quo_q;
  logic [CntW-1:0] cnt_q;
  logic            sign_q;
  fixed_t          quotient_q;
  logic            dbz_q, ovf_q;

  logic [MagW-1:0] a_ext, b_ext, a_mag, b_mag;
  logic [MagW-1:0] rem_shift, rem_next;
  logic [NumW-1:0] quo_next;
  logic            ge, last;
  fixed_t          sat_value;
  logic            sat_ovf;

  // Magnitudes are one bit wider than the word so that QMIN is exact.
  always_comb begin
    a_ext     = {bus.Dividend[BITS-1], bus.Dividend};
    b_ext     = {bus.Divisor[BITS-1], bus.Divisor};
    a_mag     = a_ext[MagW-1] ? (~a_ext + 1'b1) : a_ext;
    b_mag     = b_ext[MagW-1] ? (~b_ext + 1'b1) : b_ext;
    rem_shift = {rem_q[MagW-2:0], num_q[NumW-1]};
    ge        = (rem_shift >= dvs_q);
    rem_next  = ge ? (rem_shift - dvs_q) : rem_shift;
    quo_next  = {quo_q[NumW-2:0], ge};
    last      = (cnt_q == CntW'(1));
  end

  // The final quotient bit is folded in combinationally so DONE is entered on the last CALC edge.
  fixed_point_saturate #(
    .MagW(NumW)
  ) u_saturate (
    .mag     (quo_next),
    .neg     (sign_q),
    .value   (sat_value),
    .overflow(sat_ovf)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = (bus.Divisor == '0) ? DONE : CALC;
      CALC:    if (last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dvs_q      <= '0;
      rem_q      <= '0;
      num_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      quotient_q <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.in_valid) begin
        sign_q <= bus.Dividend[BITS-1] ^ bus.Divisor[BITS-1];
        dvs_q  <= b_mag;
        rem_q  <= '0;
        num_q  <= NumW'(a_mag) << FRAC_BITS;
        quo_q  <= '0;
        cnt_q  <= CntW'(NumW);
        dbz_q  <= 1'b0;
        ovf_q  <= 1'b0;
        if (bus.Divisor == '0) begin
          dbz_q      <= 1'b1;
          quotient_q <= bus.Dividend[BITS-1] ? QMIN : QMAX;
        end
      end else if (state_q == CALC) begin
        rem_q <= rem_next;
        num_q <= num_q << 1;
        quo_q <= quo_next;
        cnt_q <= cnt_q - 1'b1;
        if (last) begin
          quotient_q <= sat_value;
          ovf_q      <= sat_ovf;
        end
      end
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.Quotient    = quotient_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Self-checking bench for fixed_point_divider: directed scenarios plus random operands
// compared against an arithmetic model sat(trunc(A*2^FRAC_BITS / B)).
module tb_fixed_point_divider;
  import fixed_point_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errors = 0;

  fixed_point_divider_if bus ();

  fixed_point_divider dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic void ref_div(input int a, input int b, output int q, output bit dbz,
                                  output bit ovf);
    longint n;
    dbz = 1'b0;
    ovf = 1'b0;
    if (b == 0) begin
      dbz = 1'b1;
      q   = (a < 0) ? -32768 : 32767;
      return;
    end
    n = (longint'(a) * 2048) / longint'(b);
    if (n > 32767) begin
      q   = 32767;
      ovf = 1'b1;
    end else if (n < -32768) begin
      q   = -32768;
      ovf = 1'b1;
    end else begin
      q = int'(n);
    end
  endfunction

  function automatic int rand_word(input bit allow_zero);
    logic [15:0] r;
    int          sel;
    sel = int'($urandom_range(0, 9));
    r   = 16'($urandom);
    case (sel)
      0:       return allow_zero ? 0 : 1;
      1:       return -32768;
      2:       return -2048;
      3:       return 2048;
      4:       return int'($signed(r)) >>> 8;
      default: return int'($signed(r));
    endcase
  endfunction

  task automatic issue_and_wait(input int a, input int b, output int lat);
    int guard;
    @(negedge clk);
    bus.Dividend = fixed_t'(a);
    bus.Divisor  = fixed_t'(b);
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result(input int stall);
    repeat (stall) @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input int a, input int b, input int stall, output int q, output bit dbz,
                        output bit ovf, output int lat);
    issue_and_wait(a, b, lat);
    q   = int'(bus.Quotient);
    dbz = bus.div_by_zero;
    ovf = bus.overflow;
    release_result(stall);
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.Dividend  = '0;
    bus.Divisor   = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b want 1/0", bus.in_ready,
               bus.out_valid);
    end
    vectors++;
    if (bus.Quotient !== 16'sd0 || bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: Q=%0d dbz=%b ovf=%b want 0/0/0", bus.Quotient,
               bus.div_by_zero, bus.overflow);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: in_ready=%b out_valid=%b want 1/0", bus.in_ready,
               bus.out_valid);
    end
  endtask

  task automatic test_basic();
    int q, lat;
    bit dbz, ovf;
    run_op(4096, 1024, 0, q, dbz, ovf, lat);
    vectors++;
    if (q !== 8192 || dbz !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic: Q=%0d dbz=%b ovf=%b want 8192/0/0", q, dbz, ovf);
    end
    vectors++;
    if (lat !== 28) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges want 28", lat);
    end
  endtask

  task automatic test_sign_trunc();
    int a_tab[4] = '{-2048, 2048, -2048, 2048};
    int b_tab[4] = '{6144, -6144, -6144, 6144};
    int want[4]  = '{-682, -682, 682, 682};
    int q, lat;
    bit dbz, ovf;
    for (int i = 0; i < 4; i++) begin
      run_op(a_tab[i], b_tab[i], 0, q, dbz, ovf, lat);
      vectors++;
      if (q !== want[i] || dbz !== 1'b0 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL sign_trunc[%0d]: Q=%0d dbz=%b ovf=%b want %0d/0/0", i, q, dbz, ovf,
                 want[i]);
      end
    end
  endtask

  task automatic test_overflow();
    int a_tab[4] = '{32640, 5000, -32768, -32768};
    int b_tab[4] = '{128, -4, -2048, 2048};
    int want[4]  = '{32767, -32768, 32767, -32768};
    bit wovf[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    int q, lat;
    bit dbz, ovf;
    for (int i = 0; i < 4; i++) begin
      run_op(a_tab[i], b_tab[i], 1, q, dbz, ovf, lat);
      vectors++;
      if (q !== want[i] || ovf !== wovf[i] || dbz !== 1'b0) begin
        errors++;
        $display("FAIL overflow[%0d]: Q=%0d ovf=%b dbz=%b want %0d/%b/0", i, q, ovf, dbz,
                 want[i], wovf[i]);
      end
    end
  endtask

  task automatic test_zero();
    int q, lat;
    bit dbz, ovf;
    run_op(16, 0, 0, q, dbz, ovf, lat);
    vectors++;
    if (q !== 32767 || dbz !== 1'b1 || ovf !== 1'b0 || lat !== 1) begin
      errors++;
      $display("FAIL div_zero_pos: Q=%0d dbz=%b ovf=%b lat=%0d want 32767/1/0/1", q, dbz, ovf,
               lat);
    end
    run_op(-16, 0, 0, q, dbz, ovf, lat);
    vectors++;
    if (q !== -32768 || dbz !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL div_zero_neg: Q=%0d dbz=%b ovf=%b want -32768/1/0", q, dbz, ovf);
    end
    run_op(0, 16, 0, q, dbz, ovf, lat);
    vectors++;
    if (q !== 0 || dbz !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL zero_dividend: Q=%0d dbz=%b ovf=%b want 0/0/0", q, dbz, ovf);
    end
  endtask

  task automatic test_backpressure();
    int     lat;
    fixed_t q0;
    issue_and_wait(32640, 128, lat);
    q0 = bus.Quotient;
    vectors++;
    if (q0 !== 16'sd32767 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_result: Q=%0d ovf=%b want 32767/1", q0, bus.overflow);
    end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i == 2);
      bus.Dividend = 16'sd100;
      bus.Divisor  = 16'sd1;
      @(negedge clk);
      vectors++;
      if (bus.Quotient !== q0 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.overflow !== 1'b1 || bus.div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: Q=%0d v=%b rdy=%b ovf=%b dbz=%b want %0d/1/0/1/0", i,
                 bus.Quotient, bus.out_valid, bus.in_ready, bus.overflow, bus.div_by_zero, q0);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b want 1/0", bus.in_ready,
               bus.out_valid);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_pulse_ignored: in_ready=%b out_valid=%b want 1/0", bus.in_ready,
               bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_calc();
    int q, lat;
    bit dbz, ovf;
    @(negedge clk);
    bus.Dividend = 16'sd4096;
    bus.Divisor  = 16'sd1024;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.Quotient !== 16'sd0) begin
      errors++;
      $display("FAIL reset_mid_calc: in_ready=%b out_valid=%b Q=%0d want 1/0/0", bus.in_ready,
               bus.out_valid, bus.Quotient);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4096, 1024, 0, q, dbz, ovf, lat);
    vectors++;
    if (q !== 8192 || dbz !== 1'b0 || ovf !== 1'b0 || lat !== 28) begin
      errors++;
      $display("FAIL after_reset: Q=%0d dbz=%b ovf=%b lat=%0d want 8192/0/0/28", q, dbz, ovf,
               lat);
    end
  endtask

  task automatic test_random(input int n);
    int a, b, q, lat, wq, wlat, stall;
    bit dbz, ovf, wdbz, wovf;
    for (int i = 0; i < n; i++) begin
      a     = rand_word(1'b1);
      b     = ($urandom_range(0, 15) == 0) ? 0 : rand_word(1'b0);
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      ref_div(a, b, wq, wdbz, wovf);
      wlat = wdbz ? 1 : 28;
      run_op(a, b, stall, q, dbz, ovf, lat);
      vectors++;
      if (q !== wq || dbz !== wdbz || ovf !== wovf || lat !== wlat) begin
        errors++;
        $display("FAIL random[%0d] %0d/%0d: Q=%0d dbz=%b ovf=%b lat=%0d want %0d/%b/%b/%0d", i,
                 a, b, q, dbz, ovf, lat, wq, wdbz, wovf, wlat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_trunc();
    test_overflow();
    test_zero();
    test_backpressure();
    test_reset_mid_calc();
    test_random(1200);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
